// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the shared 4-operand adder arbiter.
// Contents: FSM state encoding, operand struct, slice width helper,
// slice unpack and operand sum functions. No ports.
package adder_arb_pkg;

    // Widest operand the helpers support; narrower widths are masked.
    localparam int unsigned MAX_W       = 32;
    localparam int unsigned MAX_SLICE_W = 4 * MAX_W + 1;

    // Default build: W=8 gives a 33-bit operand slice.
    localparam int unsigned DEF_W       = 8;
    localparam int unsigned DEF_SLICE_W = 4 * DEF_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [MAX_W-1:0] op_t;

    typedef struct packed {
        logic cin;
        op_t  w;
        op_t  z;
        op_t  y;
        op_t  x;
    } operands_t;

    // Width of one packed requester slice {cin, w, z, y, x}.
    function automatic int unsigned slice_width(input int unsigned w);
        return 4 * w + 1;
    endfunction

    // Split a zero-extended slice of operand width w into its fields.
    function automatic operands_t unpack_slice(input logic [MAX_SLICE_W-1:0] slice,
                                               input int unsigned w);
        operands_t              ops;
        op_t                    mask;
        logic [MAX_SLICE_W-1:0] sh;
        mask    = (w >= MAX_W) ? '1 : ((op_t'(1) << w) - op_t'(1));
        ops.x   = op_t'(slice) & mask;
        sh      = slice >> w;
        ops.y   = op_t'(sh) & mask;
        sh      = slice >> (2 * w);
        ops.z   = op_t'(sh) & mask;
        sh      = slice >> (3 * w);
        ops.w   = op_t'(sh) & mask;
        sh      = slice >> (4 * w);
        ops.cin = sh[0];
        return ops;
    endfunction

    // Zero-extended sum x + y + z + w + cin; cannot overflow MAX_W+2 bits.
    function automatic logic [MAX_W+1:0] sum_operands(input operands_t ops);
        return (MAX_W+2)'(ops.x) + (MAX_W+2)'(ops.y) + (MAX_W+2)'(ops.z)
             + (MAX_W+2)'(ops.w) + (MAX_W+2)'(ops.cin);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-wide round-robin arbiter, purely combinational.
// Ports: i_req     - request vector
//        i_ptr     - highest-priority index (search starts here, wraps)
//        o_grant_c - one-hot grant (zero when no request)
//        o_idx_c   - index of the granted request
//        o_any_c   - at least one request present
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int unsigned N   = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_grant_c,
    output logic [IDW-1:0] o_idx_c,
    output logic           o_any_c
);

    // Search i_ptr, i_ptr+1, ... modulo N; first hit wins.
    always_comb begin
        o_any_c = 1'b0;
        o_idx_c = '0;
        for (int k = 0; k < int'(N); k++) begin
            for (int n = 0; n < int'(N); n++) begin
                if (!o_any_c && i_req[n] && (n == ((int'(i_ptr) + k) % int'(N)))) begin
                    o_any_c = 1'b1;
                    o_idx_c = IDW'(n);
                end
            end
        end
        o_grant_c = o_any_c ? (N'(1) << o_idx_c) : '0;
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one x+y+z+w+cin datapath between N requesters via round-robin.
// Ports: clk, rst (sync, active-high)
//        req_valid/req_ready/req_ins - per-lane request handshake + operands
//        rsp_valid/rsp_ready         - shared response handshake
//        rsp_id, rsp_sum, rsp_zero   - response payload
// Optional (macro ADDER_ARB_STATS_EN): stat_grants (8-bit per lane),
// stat_stall (16-bit), both saturating.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int unsigned W       = 8,
    parameter  int unsigned N       = 4,
    localparam int unsigned IDW     = $clog2(N),
    localparam int unsigned SLICE_W = slice_width(W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*SLICE_W-1:0] req_ins,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W+1:0]         rsp_sum,
    output logic                 rsp_zero
`ifdef ADDER_ARB_STATS_EN
   ,output logic [N*8-1:0]       stat_grants,
    output logic [15:0]          stat_stall
`endif
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       r_id;
    logic [SLICE_W-1:0]   r_slice;
    logic [N-1:0]         w_grant;
    logic [IDW-1:0]       w_idx;
    logic                 w_any;
    logic [SLICE_W-1:0]   w_slice;
    logic [W+1:0]         w_sum;

    rr_arbiter #(.N(N)) u_rr (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_grant_c (w_grant),
        .o_idx_c   (w_idx),
        .o_any_c   (w_any)
    );

    // Operand slice of the current winner.
    always_comb begin
        w_slice = '0;
        for (int n = 0; n < int'(N); n++) begin
            if (w_idx == IDW'(n)) begin
                w_slice = req_ins[n*SLICE_W +: SLICE_W];
            end
        end
    end

    assign w_sum = (W+2)'(sum_operands(unpack_slice(MAX_SLICE_W'(r_slice), W)));

    // Next state and combinational grant; no grant while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    req_ready   = w_grant;
                    w_state_nxt = CALC;
                end
            end
            CALC:    w_state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (rst) begin
            req_ready = '0;
        end
    end

    // State, operand capture, response registers and pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_id      <= '0;
            r_slice   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_slice <= w_slice;
                        r_id    <= w_idx;
                    end
                end
                CALC: begin
                    rsp_sum   <= w_sum;
                    rsp_zero  <= (w_sum == '0);
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_ptr     <= (r_id == IDW'(N - 1)) ? '0 : r_id + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADDER_ARB_STATS_EN
    // Per-lane grant counters and response stall counter, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            if ((r_state == IDLE) && w_any) begin
                for (int n = 0; n < int'(N); n++) begin
                    if ((w_idx == IDW'(n)) && (stat_grants[n*8 +: 8] != 8'hFF)) begin
                        stat_grants[n*8 +: 8] <= stat_grants[n*8 +: 8] + 8'd1;
                    end
                end
            end
            if ((r_state == RESP) && !rsp_ready && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (W=8, N=4).
module tb_adder_arbiter;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 4 * W + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*SW-1:0] req_ins;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [W+1:0]    rsp_sum;
    logic            rsp_zero;
`ifdef ADDER_ARB_STATS_EN
    logic [N*8-1:0]  stat_grants;
    logic [15:0]     stat_stall;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ins   (req_ins),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_zero  (rsp_zero)
`ifdef ADDER_ARB_STATS_EN
       ,.stat_grants (stat_grants),
        .stat_stall  (stat_stall)
`endif
    );

    function automatic logic [SW-1:0] mk(input logic [7:0] x, input logic [7:0] y,
                                         input logic [7:0] z, input logic [7:0] w,
                                         input logic cin);
        return {cin, w, z, y, x};
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int idx = -1;
        int cnt = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (v[i]) begin
                idx = i;
                cnt++;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    task automatic set_lane(input int i, input logic [SW-1:0] s);
        req_ins[i*SW +: SW] = s;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < int'(N); i++) set_lane(i, mk(8'd3, 8'd4, 8'd5, 8'd6, 1'b1));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_req_ready cyc%0d: got %b expected 0000", c, req_ready);
            end
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rsp_valid cyc%0d: got %b expected 0", c, rsp_valid);
            end
            n_cmp++;
            if (rsp_sum !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_rsp_sum cyc%0d: got %0d expected 0", c, rsp_sum);
            end
        end
        rst       = 1'b0;
        req_valid = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (rsp_id !== 2'd0 || rsp_zero !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_regs: got id=%0d zero=%b valid=%b expected 0/0/0",
                     rsp_id, rsp_zero, rsp_valid);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        set_lane(2, mk(8'd10, 8'd20, 8'd30, 8'd40, 1'b1));
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: got %b expected 0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_calc: got valid=%b ready=%b expected 0/0000", rsp_valid, req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 10'd101 || rsp_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: got v=%b id=%0d sum=%0d z=%b expected 1/2/101/0",
                     rsp_valid, rsp_id, rsp_sum, rsp_zero);
        end
    endtask

    task automatic test_max_zero();
        @(negedge clk);
        set_lane(0, mk(8'd255, 8'd255, 8'd255, 8'd255, 1'b1));
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL max_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 10'd1021 || rsp_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL max_rsp: got v=%b id=%0d sum=%0d z=%b expected 1/0/1021/0",
                     rsp_valid, rsp_id, rsp_sum, rsp_zero);
        end
        @(negedge clk);
        set_lane(1, mk(8'd0, 8'd0, 8'd0, 8'd0, 1'b0));
        req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL zero_grant: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 10'd0 || rsp_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_rsp: got v=%b id=%0d sum=%0d z=%b expected 1/1/0/1",
                     rsp_valid, rsp_id, rsp_sum, rsp_zero);
        end
    endtask

    task automatic test_fairness();
        int g_lane[$];
        int g_cyc[$];
        int r_ids[$];
        int r_sums[$];
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(N); i++) set_lane(i, mk(8'(i + 1), 8'(i), 8'd0, 8'd0, 1'b1));
        req_valid = 4'b1111;
        for (int c = 0; c < 60 && r_ids.size() < 6; c++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                g_lane.push_back(onehot_idx(req_ready));
                g_cyc.push_back(c);
            end
            if (rsp_valid === 1'b1) begin
                r_ids.push_back(int'(rsp_id));
                r_sums.push_back(int'(rsp_sum));
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;
        n_cmp++;
        if (r_ids.size() != 6 || g_lane.size() < 6) begin
            n_fail++;
            $display("FAIL fair_timeout: got %0d grants %0d responses expected 6/6",
                     g_lane.size(), r_ids.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (g_lane[k] != exp_order[k]) begin
                    n_fail++;
                    $display("FAIL fair_grant[%0d]: got %0d expected %0d", k, g_lane[k], exp_order[k]);
                end
                n_cmp++;
                if (r_ids[k] != exp_order[k] || r_sums[k] != 2 * exp_order[k] + 2) begin
                    n_fail++;
                    $display("FAIL fair_rsp[%0d]: got id=%0d sum=%0d expected %0d/%0d",
                             k, r_ids[k], r_sums[k], exp_order[k], 2 * exp_order[k] + 2);
                end
                if (k > 0) begin
                    n_cmp++;
                    if (g_cyc[k] - g_cyc[k-1] != 3) begin
                        n_fail++;
                        $display("FAIL fair_interval[%0d]: got %0d expected 3", k, g_cyc[k] - g_cyc[k-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        // rr_ptr is 2 here: lanes 0 and 3 request, lane 3 must win first.
        rsp_ready = 1'b0;
        set_lane(3, mk(8'd50, 8'd50, 8'd50, 8'd50, 1'b0));
        set_lane(0, mk(8'd1, 8'd1, 8'd1, 8'd1, 1'b1));
        req_valid = 4'b1001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_grant: got %b expected 1000", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_calc_ready: got %b expected 0000", req_ready);
        end
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 10'd200 ||
                rsp_zero !== 1'b0 || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%0d z=%b rdy=%b expected 1/3/200/0/0000",
                         s, rsp_valid, rsp_id, rsp_sum, rsp_zero, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_next_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 10'd5) begin
            n_fail++;
            $display("FAIL bp_next_rsp: got v=%b id=%0d sum=%0d expected 1/0/5", rsp_valid, rsp_id, rsp_sum);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_lane(2, mk(8'd7, 8'd7, 8'd7, 8'd7, 1'b0));
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_grant: got %b expected 0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL mid_abandon[%0d]: got v=%b rdy=%b expected 0/0000", c, rsp_valid, req_ready);
            end
            @(negedge clk);
        end
        req_valid = 4'b1001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_ptr_cleared: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 10'd5) begin
            n_fail++;
            $display("FAIL mid_after_rsp: got v=%b id=%0d sum=%0d expected 1/0/5", rsp_valid, rsp_id, rsp_sum);
        end
    endtask

    initial begin
        req_ins = '0;
        test_reset();
        test_single();
        test_max_zero();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
